// File: rtl/ctl_arb_pkg.sv
// Shared types and constants for the control-source arbiter: source ids,
// joystick bit positions, keyboard scan codes and the button bundle.
package ctl_arb_pkg;

    typedef enum logic [1:0] {
        SRC_KBD = 2'd0,
        SRC_USB = 2'd1,
        SRC_DB  = 2'd2
    } src_e;

    typedef enum logic {
        ST_IDLE,
        ST_OWNED
    } arb_state_e;

    localparam int unsigned BTN_R      = 0;
    localparam int unsigned BTN_L      = 1;
    localparam int unsigned BTN_THRUST = 4;
    localparam int unsigned BTN_FIRE   = 5;
    localparam int unsigned BTN_START  = 6;

    // Left/right are matched on the low byte only (extended-key prefix ignored)
    localparam logic [7:0] SC_LEFT_LO  = 8'h6B;
    localparam logic [7:0] SC_RIGHT_LO = 8'h74;
    localparam logic [8:0] SC_THRUST   = 9'h029;
    localparam logic [8:0] SC_FIRE     = 9'h014;
    localparam logic [8:0] SC_START_A  = 9'h005;
    localparam logic [8:0] SC_START_B  = 9'h016;

    typedef struct packed {
        logic start;
        logic fire;
        logic thrust;
        logic left;
        logic right;
    } btns_t;

    function automatic logic any_btn(input btns_t b);
        return |b;
    endfunction

endpackage

// File: rtl/kbd_ctl_decode.sv
// PS/2 event decoder: detects ps2_key[10] toggles and holds one latch per
// game button, set/cleared by the pressed flag of the matching scan code.
module kbd_ctl_decode
    import ctl_arb_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    output btns_t       kbd_btn,
    output btns_t       kbd_btn_nxt
);

    logic  key_tgl_q;
    btns_t btn_q;
    btns_t btn_d;
    logic  key_event;
    logic  pressed;

    assign key_event = ps2_key[10] != key_tgl_q;
    assign pressed   = ps2_key[9];

    always_comb begin
        btn_d = btn_q;
        if (key_event) begin
            if (ps2_key[7:0] == SC_LEFT_LO) begin
                btn_d.left = pressed;
            end else if (ps2_key[7:0] == SC_RIGHT_LO) begin
                btn_d.right = pressed;
            end else if (ps2_key[8:0] == SC_THRUST) begin
                btn_d.thrust = pressed;
            end else if (ps2_key[8:0] == SC_FIRE) begin
                btn_d.fire = pressed;
            end else if (ps2_key[8:0] == SC_START_A || ps2_key[8:0] == SC_START_B) begin
                btn_d.start = pressed;
            end
        end
    end

    // Capturing the toggle bit during reset suppresses a phantom event on exit
    always_ff @(posedge clk_sys) begin
        key_tgl_q <= ps2_key[10];
        if (reset) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn_d;
        end
    end

    assign kbd_btn     = btn_q;
    assign kbd_btn_nxt = btn_d;

endmodule

// File: rtl/ctl_source_arbiter.sv
// Grants the game controls to one of keyboard / USB / DB joystick, holds the
// grant while the owner is active and releases it after idle frames.
module ctl_source_arbiter
    import ctl_arb_pkg::*;
#(
    parameter int unsigned RELEASE_FRAMES = 120
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy_usb,
    input  logic [15:0] joy_db,
    input  logic        db_ena,
    input  logic        vsync,
    output logic        ctl_left,
    output logic        ctl_right,
    output logic        ctl_thrust,
    output logic        ctl_fire,
    output logic        ctl_start,
    output logic [1:0]  owner,
    output logic        owner_valid
);

    localparam logic [7:0] REL_CNT = 8'(RELEASE_FRAMES);

    btns_t      kbd_btn;
    btns_t      kbd_btn_nxt;
    btns_t      usb_btn;
    btns_t      db_btn;
    btns_t      own_btn;
    btns_t      ctl_d;

    arb_state_e state_q, state_d;
    src_e       owner_q, owner_d;
    logic [7:0] cnt_q, cnt_d;
    logic       vsync_q;
    logic       vs_rise;
    logic       act_kbd, act_usb, act_db, owner_act;
    logic       unused_joy;

    kbd_ctl_decode u_kbd (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ps2_key     (ps2_key),
        .kbd_btn     (kbd_btn),
        .kbd_btn_nxt (kbd_btn_nxt)
    );

    assign usb_btn = '{start:  joy_usb[BTN_START],
                       fire:   joy_usb[BTN_FIRE],
                       thrust: joy_usb[BTN_THRUST],
                       left:   joy_usb[BTN_L],
                       right:  joy_usb[BTN_R]};

    assign db_btn  = db_ena ? '{start:  joy_db[BTN_START],
                                fire:   joy_db[BTN_FIRE],
                                thrust: joy_db[BTN_THRUST],
                                left:   joy_db[BTN_L],
                                right:  joy_db[BTN_R]} : '0;

    assign unused_joy = ^{joy_usb[15:7], joy_usb[3:2], joy_db[15:7], joy_db[3:2]};

    // Keyboard activity looks at the pending latch value so a key event and a
    // joystick press arriving together are arbitrated in the same cycle.
    assign act_kbd = any_btn(kbd_btn_nxt);
    assign act_usb = any_btn(usb_btn);
    assign act_db  = any_btn(db_btn);
    assign vs_rise = vsync & ~vsync_q;

    always_comb begin
        unique case (owner_q)
            SRC_KBD: begin own_btn = kbd_btn; owner_act = act_kbd; end
            SRC_USB: begin own_btn = usb_btn; owner_act = act_usb; end
            default: begin own_btn = db_btn;  owner_act = act_db;  end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        ctl_d       = '0;
        ctl_d.start = kbd_btn.start | usb_btn.start | db_btn.start;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (act_kbd) begin
                    state_d = ST_OWNED;
                    owner_d = SRC_KBD;
                end else if (act_usb) begin
                    state_d = ST_OWNED;
                    owner_d = SRC_USB;
                end else if (act_db) begin
                    state_d = ST_OWNED;
                    owner_d = SRC_DB;
                end
            end
            ST_OWNED: begin
                ctl_d.left   = own_btn.left;
                ctl_d.right  = own_btn.right;
                ctl_d.thrust = own_btn.thrust;
                ctl_d.fire   = own_btn.fire;
                if (owner_q == SRC_DB && !db_ena) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (owner_act) begin
                    cnt_d = '0;
                end else if (cnt_q == REL_CNT) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (vs_rise && cnt_q != '1) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        vsync_q <= vsync;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= SRC_KBD;
            cnt_q      <= '0;
            ctl_left   <= 1'b0;
            ctl_right  <= 1'b0;
            ctl_thrust <= 1'b0;
            ctl_fire   <= 1'b0;
            ctl_start  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            ctl_left   <= ctl_d.left;
            ctl_right  <= ctl_d.right;
            ctl_thrust <= ctl_d.thrust;
            ctl_fire   <= ctl_d.fire;
            ctl_start  <= ctl_d.start;
        end
    end

    assign owner       = owner_q;
    assign owner_valid = state_q == ST_OWNED;

endmodule

// File: tb/tb_ctl_source_arbiter.sv
// Self-checking bench for ctl_source_arbiter: directed scenarios plus a
// randomized run compared against a behavioural ownership model.
module tb_ctl_source_arbiter;

    localparam int unsigned RF = 3;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joy_usb;
    logic [15:0] joy_db;
    logic        db_ena;
    logic        vsync;
    logic        ctl_left, ctl_right, ctl_thrust, ctl_fire, ctl_start;
    logic [1:0]  owner;
    logic        owner_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: button bundles ordered {start, fire, thrust, right, left}
    bit       m_owned;
    int       m_owner;
    int       m_frames;
    bit [4:0] m_keys;
    bit [4:0] m_ctl;
    bit       m_prev_tgl;
    bit       m_prev_vs;

    ctl_source_arbiter #(.RELEASE_FRAMES(RF)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ps2_key     (ps2_key),
        .joy_usb     (joy_usb),
        .joy_db      (joy_db),
        .db_ena      (db_ena),
        .vsync       (vsync),
        .ctl_left    (ctl_left),
        .ctl_right   (ctl_right),
        .ctl_thrust  (ctl_thrust),
        .ctl_fire    (ctl_fire),
        .ctl_start   (ctl_start),
        .owner       (owner),
        .owner_valid (owner_valid)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic bit [4:0] joy_btns(input logic [15:0] w);
        return {w[6], w[5], w[4], w[0], w[1]};
    endfunction

    function automatic int key_slot(input logic [8:0] code);
        if (code[7:0] == 8'h6B) return 0;
        if (code[7:0] == 8'h74) return 1;
        if (code == 9'h029) return 2;
        if (code == 9'h014) return 3;
        if (code == 9'h005 || code == 9'h016) return 4;
        return -1;
    endfunction

    // Advance one clock and update the model with the inputs seen at that edge
    task automatic tick();
        logic        r, e, v;
        logic [10:0] k;
        logic [15:0] u, d;
        bit [4:0]    kn, ub, dbb, sel, nctl;
        bit          act [3];
        int          slot;
        r = reset; e = db_ena; v = vsync; k = ps2_key; u = joy_usb; d = joy_db;
        @(posedge clk_sys);
        #1;
        if (r) begin
            m_owned = 0; m_owner = 0; m_frames = 0;
            m_keys = '0; m_ctl = '0; m_prev_tgl = k[10];
        end else begin
            kn = m_keys;
            if (k[10] != m_prev_tgl) begin
                slot = key_slot(k[8:0]);
                if (slot >= 0) kn[slot] = k[9];
            end
            m_prev_tgl = k[10];
            ub  = joy_btns(u);
            dbb = e ? joy_btns(d) : 5'b0;
            act[0] = kn != 0; act[1] = ub != 0; act[2] = dbb != 0;
            nctl = '0;
            nctl[4] = m_keys[4] | ub[4] | dbb[4];
            if (!m_owned) begin
                for (int s = 2; s >= 0; s--)
                    if (act[s]) begin m_owned = 1; m_owner = s; m_frames = 0; end
            end else begin
                sel = (m_owner == 0) ? m_keys : (m_owner == 1) ? ub : dbb;
                nctl[3:0] = sel[3:0];
                if (m_owner == 2 && !e) begin
                    m_owned = 0; m_frames = 0;
                end else if (act[m_owner]) begin
                    m_frames = 0;
                end else if (m_frames == RF) begin
                    m_owned = 0; m_frames = 0;
                end else if (v && !m_prev_vs) begin
                    m_frames = (m_frames < 255) ? m_frames + 1 : 255;
                end
            end
            m_ctl  = nctl;
            m_keys = kn;
        end
        m_prev_vs = v;
    endtask

    task automatic idle_inputs();
        joy_usb = '0; joy_db = '0; db_ena = 1'b0; vsync = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({owner_valid, owner} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_owner: got valid=%b owner=%0d want valid=0 owner=0", owner_valid, owner);
        end
        n_checks++;
        if ({ctl_left, ctl_right, ctl_thrust, ctl_fire, ctl_start} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {ctl_left, ctl_right, ctl_thrust, ctl_fire, ctl_start});
        end
        tick();
        n_checks++;
        if (owner_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_quiet: got valid=%b want 0", owner_valid);
        end
    endtask

    task automatic test_usb_grant();
        do_reset();
        joy_usb = 16'h0010;
        tick();
        n_checks++;
        if ({owner_valid, owner} !== 3'b101) begin
            n_fail++;
            $display("FAIL usb_grant: got valid=%b owner=%0d want valid=1 owner=1", owner_valid, owner);
        end
        n_checks++;
        if (ctl_thrust !== 1'b0) begin
            n_fail++;
            $display("FAIL usb_thrust_early: got %b want 0", ctl_thrust);
        end
        tick();
        n_checks++;
        if (ctl_thrust !== 1'b1) begin
            n_fail++;
            $display("FAIL usb_thrust: got %b want 1", ctl_thrust);
        end
    endtask

    task automatic test_no_preempt();
        do_reset();
        joy_usb = 16'h0001;
        tick();
        tick();
        joy_db = 16'h0020; db_ena = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({owner, ctl_fire, ctl_right} !== 4'b0101) begin
            n_fail++;
            $display("FAIL no_preempt: got owner=%0d fire=%b right=%b want owner=1 fire=0 right=1",
                     owner, ctl_fire, ctl_right);
        end
    endtask

    task automatic test_release();
        do_reset();
        joy_usb = 16'h0010;
        tick();
        joy_usb = '0;
        tick();
        // First pulse held high for several cycles counts as one frame
        for (int p = 1; p <= 3; p++) begin
            vsync = 1'b1;
            tick();
            if (p == 1) begin tick(); tick(); tick(); end
            vsync = 1'b0;
            n_checks++;
            if (owner_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL release_hold_%0d: got valid=%b want 1", p, owner_valid);
            end
            if (p < 3) tick();
        end
        tick();
        n_checks++;
        if (owner_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_drop: got valid=%b want 0", owner_valid);
        end
        vsync = 1'b1; tick(); vsync = 1'b0; tick(); tick();
        n_checks++;
        if ({owner_valid, ctl_left, ctl_right, ctl_thrust, ctl_fire} !== 5'b0) begin
            n_fail++;
            $display("FAIL release_fourth: got valid=%b ctl=%b want 0 0000", owner_valid,
                     {ctl_left, ctl_right, ctl_thrust, ctl_fire});
        end
    endtask

    task automatic test_cancel();
        do_reset();
        joy_usb = 16'h0001;
        tick();
        joy_usb = '0;
        tick();
        for (int p = 0; p < 2; p++) begin
            vsync = 1'b1; tick(); vsync = 1'b0; tick();
        end
        vsync = 1'b1; joy_usb = 16'h0001;
        tick();
        vsync = 1'b0; joy_usb = '0;
        tick();
        for (int p = 0; p < 2; p++) begin
            vsync = 1'b1; tick(); vsync = 1'b0; tick();
        end
        tick();
        n_checks++;
        if (owner_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL cancel_release: got valid=%b want 1", owner_valid);
        end
    endtask

    task automatic test_kbd_priority();
        do_reset();
        ps2_key = {~ps2_key[10], 1'b1, 9'h16B};
        joy_usb = 16'h0002;
        tick();
        n_checks++;
        if ({owner_valid, owner} !== 3'b100) begin
            n_fail++;
            $display("FAIL kbd_priority: got valid=%b owner=%0d want valid=1 owner=0", owner_valid, owner);
        end
        tick();
        n_checks++;
        if (ctl_left !== 1'b1) begin
            n_fail++;
            $display("FAIL kbd_left: got %b want 1", ctl_left);
        end
        ps2_key = {~ps2_key[10], 1'b0, 9'h16B};
        joy_usb = '0;
        tick();
    endtask

    task automatic test_db_drop_start();
        do_reset();
        db_ena = 1'b1; joy_db = 16'h0020;
        tick();
        tick();
        n_checks++;
        if ({owner_valid, owner, ctl_fire} !== 4'b1101) begin
            n_fail++;
            $display("FAIL db_grant: got valid=%b owner=%0d fire=%b want 1 2 1", owner_valid, owner, ctl_fire);
        end
        joy_usb = 16'h0040;
        tick();
        n_checks++;
        if ({ctl_start, owner} !== 3'b110) begin
            n_fail++;
            $display("FAIL db_start: got start=%b owner=%0d want start=1 owner=2", ctl_start, owner);
        end
        db_ena = 1'b0;
        tick();
        n_checks++;
        if ({owner_valid, ctl_fire} !== 2'b00) begin
            n_fail++;
            $display("FAIL db_drop: got valid=%b fire=%b want 0 0", owner_valid, ctl_fire);
        end
    endtask

    task automatic test_reset_mid_owned();
        do_reset();
        db_ena = 1'b1; joy_db = 16'h0020;
        tick();
        tick();
        n_checks++;
        if (ctl_fire !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_pre: got fire=%b want 1", ctl_fire);
        end
        reset = 1'b1;
        ps2_key = {~ps2_key[10], 1'b1, 9'h014};
        tick();
        n_checks++;
        if ({owner_valid, owner, ctl_left, ctl_right, ctl_thrust, ctl_fire, ctl_start} !== 8'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got valid=%b owner=%0d ctl=%b want all 0", owner_valid, owner,
                     {ctl_left, ctl_right, ctl_thrust, ctl_fire, ctl_start});
        end
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        n_checks++;
        if ({owner_valid, ctl_fire} !== 2'b00) begin
            n_fail++;
            $display("FAIL no_spurious_key: got valid=%b fire=%b want 0 0", owner_valid, ctl_fire);
        end
    endtask

    task automatic test_random();
        logic [8:0] codes [10];
        int unsigned picks [7];
        logic [7:0] got, exp;
        codes = '{9'h16B, 9'h06B, 9'h074, 9'h174, 9'h029, 9'h014, 9'h005, 9'h016, 9'h0AA, 9'h129};
        picks = '{0, 1, 4, 5, 6, 2, 9};
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 3) == 0) vsync = ~vsync;
            if ($urandom_range(0, 7) == 0)
                joy_usb = ($urandom_range(0, 3) == 0) ? 16'($urandom) : (16'h1 << picks[$urandom_range(0, 6)]);
            else if ($urandom_range(0, 3) == 0)
                joy_usb = '0;
            if ($urandom_range(0, 7) == 0)
                joy_db = ($urandom_range(0, 3) == 0) ? 16'($urandom) : (16'h1 << picks[$urandom_range(0, 6)]);
            else if ($urandom_range(0, 3) == 0)
                joy_db = '0;
            if ($urandom_range(0, 39) == 0) db_ena = ~db_ena;
            if ($urandom_range(0, 7) == 0)
                ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), codes[$urandom_range(0, 9)]};
            else if ($urandom_range(0, 9) == 0)
                ps2_key[9:0] = 10'($urandom);
            tick();
            got = {owner_valid, owner_valid ? owner : 2'b00,
                   ctl_left, ctl_right, ctl_thrust, ctl_fire, ctl_start};
            exp = {m_owned, m_owned ? 2'(m_owner) : 2'b00,
                   m_ctl[0], m_ctl[1], m_ctl[2], m_ctl[3], m_ctl[4]};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got {valid,owner,L,R,T,F,S}=%b want %b", c, got, exp);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        m_owned = 0; m_owner = 0; m_frames = 0; m_keys = '0; m_ctl = '0;
        m_prev_tgl = 0; m_prev_vs = 0;
        reset = 1'b1;
        ps2_key = '0;
        idle_inputs();
        test_reset();
        test_usb_grant();
        test_no_preempt();
        test_release();
        test_cancel();
        test_kbd_priority();
        test_db_drop_start();
        test_reset_mid_owned();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctl_source_arbiter.md
CTL_SOURCE_ARBITER -- requirements
Module: ctl_source_arbiter

Interface
REQ-001 Parameter RELEASE_FRAMES, default 120, is the number of idle frames before ownership is dropped; legal range is 1..255.
REQ-002 clk_sys  in  1  system clock; the one clock of the block.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ps2_key  in  11  keyboard event word: bit 10 toggles on each event, bit 9 = pressed, bits 8:0 = scan code.
REQ-005 joy_usb  in  16  USB joystick word: bit 0 R, 1 L, 4 thrust, 5 fire, 6 start.
REQ-006 joy_db  in  16  DB9/DB15 joystick word, same bit map as joy_usb.
REQ-007 db_ena  in  1  DB joystick source enabled.
REQ-008 vsync  in  1  frame sync, active-high, synchronous to clk_sys.
REQ-009 ctl_left, ctl_right, ctl_thrust, ctl_fire, ctl_start  out  1 each  arbitrated game controls.
REQ-010 owner  out  2  current owner: 0 = keyboard, 1 = USB, 2 = DB; 3 is unused.
REQ-011 owner_valid  out  1  a source currently owns the controls.

Function
REQ-012 Keyboard decode: a change of ps2_key[10] versus its previous registered value updates a held button latch with ps2_key[9].
- Left = code X6B (bit 8 don't-care); right = X74; thrust = 029; fire = 014; start = 005 or 016.
- The latch is valid one cycle after the toggle.
REQ-013 Source activity: a source is active when any of its five buttons is set; the DB source is active only when db_ena=1.
REQ-014 The FSM has two states, IDLE and OWNED.
REQ-015 IDLE: owner_valid=0; left/right/thrust/fire are 0. If any source is active, the next cycle enters OWNED with the highest-priority active source (keyboard > USB > DB) and the frame counter cleared.
REQ-016 OWNED: left/right/thrust/fire follow the owner's buttons, registered, with 1-cycle latency. Activity on another source does not preempt ownership.
REQ-017 In OWNED, an active owner clears the frame counter. An inactive owner increments the counter on each vsync rising edge.
REQ-018 When the counter equals RELEASE_FRAMES, the next cycle enters IDLE with the counter cleared.
REQ-019 Release and new grant never happen in the same cycle: after release, IDLE lasts at least one cycle.
REQ-020 Owner activity on the same cycle as the terminal vsync edge cancels the release (the clear wins over the increment).
REQ-021 If owner=DB and db_ena falls, the next cycle enters IDLE immediately, ignoring the counter.
REQ-022 ctl_start is the registered OR of all sources' start bits in every state, so start is never blocked by ownership.
REQ-023 The counter is 8 bits and saturates; it cannot wrap past RELEASE_FRAMES.
REQ-024 vsync edge detection uses a 1-cycle delayed copy; vsync held high counts once.

Reset
REQ-025 Reset forces IDLE, counter=0, owner=0, owner_valid=0, all ctl_* outputs=0, and all keyboard latches=0.
REQ-026 Reset captures the current ps2_key[10] as the previous value, so no spurious event fires on release from reset.
REQ-027 Reset asserted mid-OWNED takes effect on the next clk_sys edge and overrides every other condition.

Structure
REQ-028 A shared package ctl_arb_pkg holds:
- the source enum (SRC_KBD=0, SRC_USB=1, SRC_DB=2);
- the button-index constants (R=0, L=1, THRUST=4, FIRE=5, START=6);
- the keyboard scan-code constants.
REQ-029 One sub-module, kbd_ctl_decode, holds the ps2_key toggle detection and the button latches (REQ-012, REQ-026).

Verification
REQ-030 After reset, joy_usb=0x0010 -> next cycle: owner=1, owner_valid=1; the cycle after: ctl_thrust=1.
REQ-031 USB owns; joy_db=0x0020 with db_ena=1 -> ctl_fire stays 0 and owner stays 1.
REQ-032 RELEASE_FRAMES=3; USB owns and goes idle; 3 vsync pulses -> owner_valid=0 one cycle after the third rising edge. A 4th pulse with everything idle -> no change.
REQ-033 ps2_key toggle with code 0x16B, pressed=1, at the same time as joy_usb=0x0002 -> keyboard wins (owner=0) and ctl_left=1.
REQ-034 DB owns; db_ena falls -> owner_valid=0 next cycle. joy_usb start bit 0x0040 while DB owns -> ctl_start=1 one cycle later.
REQ-035 Reset asserted while OWNED with ctl_fire=1 -> all outputs 0 next cycle. An unchanged ps2_key[10] after reset -> no key event.
